// File: rtl/imem_loadable_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable_if
//  Description : Fetch port and byte-serial program-loader port of the
//                loadable instruction memory.
//                master = CPU/loader side, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loadable_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]     A;
    logic [31:0]     RD;
    logic [31:0]     mVal;
    logic            fault;
    logic            hold;
    logic            ld_start;
    logic            ld_valid;
    logic [7:0]      ld_byte;
    logic            ld_end;
    logic            ld_ready;
    logic [ADDR_W:0] ld_count;

    modport master (
        output A, ld_start, ld_valid, ld_byte, ld_end,
        input  RD, mVal, fault, hold, ld_ready, ld_count
    );

    modport slave (
        input  A, ld_start, ld_valid, ld_byte, ld_end,
        output RD, mVal, fault, hold, ld_ready, ld_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable
//  Description : Instruction memory with asynchronous word fetch whose
//                contents are swept to a branch-to-self fill word after reset
//                and then written by a byte-serial little-endian loader.
//                The CPU is held and parked on the fill word while clearing
//                or loading; out-of-range / misaligned fetches are flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loadable #(
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] FILL_INSTR = 32'hEAFF_FFFE
) (
    input  logic           clk,
    input  logic           reset,
    imem_loadable_if.slave bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              hold_q, hold_d;
    logic              ld_ready_q, ld_ready_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem [DEPTH];

    logic              fetch_fault;
    logic [31:0]       fetch_word;

    // Next-state logic: clear sweep, idle wait, and byte assembly during load.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        ld_count_d = ld_count_q;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = FILL_INSTR;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    byte_cnt_d = 2'd0;
                    ld_count_d = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over both the concurrent byte and ld_end.
                if (bus.ld_start) begin
                    ptr_d      = '0;
                    byte_cnt_d = 2'd0;
                    ld_count_d = '0;
                end else begin
                    if (bus.ld_valid) begin
                        case (byte_cnt_q)
                            2'd0: asm_d[7:0]   = bus.ld_byte;
                            2'd1: asm_d[15:8]  = bus.ld_byte;
                            2'd2: asm_d[23:16] = bus.ld_byte;
                            default: begin
                                mem_we     = 1'b1;
                                mem_wdata  = {bus.ld_byte, asm_q};
                                ld_count_d = ld_count_q + 1'b1;
                                ptr_d      = ptr_q + 1'b1;
                                if (ptr_q == PTR_LAST) begin
                                    state_d = ST_IDLE;
                                end
                            end
                        endcase
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                    // Any partially assembled word is simply dropped.
                    if (bus.ld_end) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase

        hold_d     = (state_d != ST_IDLE);
        ld_ready_d = (state_d == ST_LOAD);
    end

    // Control registers, synchronous reset into the clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            ld_count_q <= '0;
            hold_q     <= 1'b1;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            ld_count_q <= ld_count_d;
            hold_q     <= hold_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    // Single write port shared by the clear sweep and the loader.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Asynchronous fetch; faulting or held fetches see the park instruction.
    assign fetch_fault = (|bus.A[1:0]) | (|bus.A[31:ADDR_W+2]);
    assign fetch_word  = (fetch_fault || hold_q) ? FILL_INSTR
                                                 : mem[bus.A[ADDR_W+1:2]];

    assign bus.RD       = fetch_word;
    assign bus.mVal     = fetch_word;
    assign bus.fault    = fetch_fault;
    assign bus.hold     = hold_q;
    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_count = ld_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loadable
//  Description : Scoreboard bench for imem_loadable (ADDR_W=4). Stimulus
//                updates a word-array reference model and queues the expected
//                fetch/status view; a negedge monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loadable;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] FILL  = 32'hEAFF_FFFE;
    localparam int M_CLEAR = 0;
    localparam int M_IDLE  = 1;
    localparam int M_LOAD  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loadable_if #(.ADDR_W(AW)) bus ();

    imem_loadable #(.ADDR_W(AW), .FILL_INSTR(FILL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] rd;
        logic        fault;
        logic        hold;
        logic        ready;
        logic [AW:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: memory words, loader mode and collected bytes.
    logic [31:0] mmem [DEPTH];
    int          mode = M_CLEAR;
    int          clr_idx = 0;
    int          mptr = 0;
    int          mcnt = 0;
    logic [7:0]  part[$];

    task automatic cmp(input string nm, input logic [31:0] a,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s A=%h actual=%h required=%h", nm, a, act, req);
        end
    endtask

    // Monitor: compare the presented outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".RD"},       e.a, bus.RD,   e.rd);
            cmp({e.name, ".mVal"},     e.a, bus.mVal, e.rd);
            cmp({e.name, ".fault"},    e.a, 32'(bus.fault),    32'(e.fault));
            cmp({e.name, ".hold"},     e.a, 32'(bus.hold),     32'(e.hold));
            cmp({e.name, ".ld_ready"}, e.a, 32'(bus.ld_ready), 32'(e.ready));
            cmp({e.name, ".ld_count"}, e.a, 32'(bus.ld_count), 32'(e.cnt));
        end
    end

    task automatic model_edge(input bit r, input bit s, input bit v,
                              input logic [7:0] b, input bit e);
        if (r) begin
            mode = M_CLEAR; clr_idx = 0; mptr = 0; mcnt = 0; part.delete();
        end else if (mode == M_CLEAR) begin
            mmem[clr_idx] = FILL;
            clr_idx++;
            if (clr_idx == DEPTH) mode = M_IDLE;
        end else if (mode == M_IDLE) begin
            if (s) begin
                mode = M_LOAD; mptr = 0; mcnt = 0; part.delete();
            end
        end else begin
            if (s) begin
                mptr = 0; mcnt = 0; part.delete();
            end else begin
                if (v) begin
                    part.push_back(b);
                    if (part.size() == 4) begin
                        mmem[mptr] = {part[3], part[2], part[1], part[0]};
                        mptr++; mcnt++;
                        part.delete();
                        if (mptr == DEPTH) mode = M_IDLE;
                    end
                end
                if (e) begin
                    mode = M_IDLE; part.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v,
                        input logic [7:0] b, input bit e);
        reset = r; bus.ld_start = s; bus.ld_valid = v; bus.ld_byte = b; bus.ld_end = e;
        model_edge(r, s, v, b, e);
        @(posedge clk); #1;
        reset = 1'b0; bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_end = 1'b0;
        bus.ld_byte = 8'($urandom);
    endtask

    task automatic check(input string nm, input logic [31:0] a);
        exp_t e;
        e.name  = nm;
        e.a     = a;
        e.fault = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
        e.hold  = (mode != M_IDLE);
        e.ready = (mode == M_LOAD);
        e.cnt   = (AW+1)'(mcnt);
        e.rd    = (e.fault || e.hold) ? FILL : mmem[a[AW+1:2]];
        bus.A = a;
        sb.push_back(e);
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 9);
        a = 32'd0;
        a[AW+1:2] = AW'($urandom_range(0, DEPTH-1));
        if (k == 8) a[1:0] = 2'($urandom_range(1, 3));
        if (k == 9) a = a | (32'd1 << $urandom_range(AW+2, 31));
        return a;
    endfunction

    task automatic load_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) step(0, 0, 1, bytes[i], 0);
    endtask

    initial begin
        logic [7:0] bl[$];
        int r;
        bit rs, st, en, v;
        bus.A = 32'd0; bus.ld_start = 1'b0; bus.ld_valid = 1'b0;
        bus.ld_byte = 8'd0; bus.ld_end = 1'b0;

        // Reset sweep: hold stays high for exactly DEPTH cycles.
        step(1, 0, 0, 8'h00, 0);
        check("reset", 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, (i == 3), (i == 4), 8'h55, (i == 5));
            check("sweep", rand_addr());
        end
        for (int i = 0; i < DEPTH; i++) check("swept", 32'(i * 4));
        check("range64", 32'd64);
        check("misalign2", 32'd2);

        // Basic three-word load.
        step(0, 1, 0, 8'h00, 0);
        bl = '{8'h31, 8'h20, 8'hA0, 8'hE3, 8'hE6, 8'h30, 8'hA0, 8'hE3,
               8'h03, 8'h20, 8'h22, 8'hE0};
        load_bytes(bl);
        check("loading", 32'd0);
        step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) check("basic", 32'(i * 4));

        // Partial word discarded, then ld_end together with 4th byte.
        step(0, 1, 0, 8'h00, 0);
        bl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load_bytes(bl);
        step(0, 0, 0, 8'h00, 1);
        check("partial0", 32'd0);
        check("partial1", 32'd4);
        step(0, 1, 0, 8'h00, 0);
        bl = '{8'h11, 8'h22, 8'h33};
        load_bytes(bl);
        step(0, 0, 1, 8'h44, 1);
        check("end4th", 32'd0);
        check("end4th1", 32'd4);

        // Full fill with back-to-back bytes, then an ignored 65th byte.
        step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4*DEPTH; i++) step(0, 0, 1, 8'($urandom), 0);
        check("full", 32'd60);
        step(0, 0, 1, 8'h99, 0);
        check("byte65", 32'd0);
        check("full15", 32'd60);

        // Restart drops the concurrent byte.
        step(0, 1, 0, 8'h00, 0);
        bl = '{8'h01, 8'h02, 8'h03};
        load_bytes(bl);
        step(0, 1, 1, 8'h77, 0);
        bl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        load_bytes(bl);
        step(0, 0, 0, 8'h00, 1);
        check("restart0", 32'd0);
        check("restart1", 32'd4);

        // Reset mid-load, ld_start during the sweep is ignored.
        step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 8'($urandom), 0);
        check("midload", 32'd4);
        step(1, 0, 1, 8'h12, 0);
        check("rst_mid", 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, (i % 3 == 0), 1, 8'h5A, 0);
            check("reclear", rand_addr());
        end
        for (int i = 0; i < DEPTH; i++) check("recleared", 32'(i * 4));

        // Randomised sessions with occasional restarts, ends and resets.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 199);
            rs = (r == 0);
            st = (r >= 1 && r <= 6);
            en = (r >= 7 && r <= 12);
            v  = ($urandom_range(0, 3) != 0);
            step(rs, st, v, 8'($urandom), en);
            check("rand", rand_addr());
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) check("final", 32'(i * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
